fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; legal values are 2 and 4.
REQ-003 Port clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port nrst  in  1  reset, synchronous, active-low.
REQ-005 Port stall  in  1  decode stall from the control unit; holds the presented instruction.
REQ-006 Port redirect  in  1  taken-branch or mispredict redirect request.
REQ-007 Port redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-008 Port imem_req  out  1  single-cycle fetch request; memory always accepts it.
REQ-009 Port imem_addr  out  32  word-aligned fetch address, valid while imem_req=1.
REQ-010 Port imem_rvalid  in  1  read-data valid, arriving 1 or more cycles after imem_req.
REQ-011 Port imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-012 Port instr_out  out  32  buffer head instruction; 32'h0000_0013 (NOP) when the buffer is empty.
REQ-013 Port pc_out  out  32  PC of instr_out; 0 when the buffer is empty.
REQ-014 Port instr_valid  out  1  buffer non-empty.
REQ-015 Port chng2nop  out  1  registered one-cycle pulse, high the cycle after redirect is sampled.

Function
REQ-016 The unit SHALL hold state registers fetch_pc (32 bits), a BUF_DEPTH-entry {pc, instr} FIFO with a count, and a state machine with states RESET, IDLE, WAIT and DROP.
REQ-017 At most one memory request SHALL be outstanding: WAIT and DROP mean outstanding; IDLE means none.
REQ-018 Pop SHALL occur when instr_valid=1, stall=0 and redirect=0.
REQ-019 push = imem_rvalid in WAIT with redirect=0; {fetch_pc_of_request, imem_rdata} enters the tail.
REQ-020 An issue SHALL be allowed in IDLE, or in WAIT/DROP in a cycle with imem_rvalid=1, and only when redirect=0 and count+push-pop < BUF_DEPTH.
REQ-021 On issue: imem_req=1 and imem_addr=fetch_pc (the redirected fetch_pc in DROP); fetch_pc advances by 4 in the same cycle; next state is WAIT.
REQ-022 The issue rule SHALL make FIFO overflow impossible; simultaneous push and pop leave count unchanged.
REQ-023 Transitions: RESET->IDLE when nrst=1; WAIT->IDLE on rvalid with no issue; DROP->IDLE on rvalid with no issue, with the data discarded.
REQ-024 Redirect SHALL take priority over stall, push, pop and issue.
REQ-025 On redirect: FIFO count->0; fetch_pc<={redirect_pc[31:2],2'b00}; no issue that cycle.
REQ-026 On redirect, the next state SHALL be: IDLE from IDLE; DROP from WAIT with rvalid=0; IDLE from WAIT with rvalid=1 (response discarded); DROP from DROP with rvalid=0; IDLE from DROP with rvalid=1.
REQ-027 Responses arriving in DROP SHALL never enter the FIFO.
REQ-028 Best-case latency: issue in cycle T, rvalid in T+1, instr_valid=1 in T+2.
REQ-029 With 1-cycle memory and no stall, sustained throughput SHALL be one instruction per cycle.
REQ-030 With stall=1, instr_out and pc_out SHALL be unchanged, and fetching continues until the FIFO is full.
REQ-031 fetch_pc wraps modulo 2^32; FFFF_FFFC+4 = 0000_0000.
REQ-032 imem_rvalid in IDLE or RESET is a protocol error and SHALL be ignored.

Reset
REQ-033 While nrst=0 the state machine SHALL be in RESET, with fetch_pc=RESET_PC, count=0, chng2nop=0 and imem_req=0.
REQ-034 While nrst=0, instr_valid=0, instr_out=NOP and pc_out=0.
REQ-035 Reset asserted mid-operation SHALL abandon any outstanding request; a late rvalid after reset SHALL be ignored.
REQ-036 The first issue after reset SHALL occur in the first cycle with nrst=1, with imem_addr=RESET_PC.

Verification
REQ-037 Reset release with a 1-cycle memory returning 0x00A00093, 0x00100113, ... -> imem_addr sequence 0,4,8,... on consecutive cycles; instr_out=0x00A00093, pc_out=0 two cycles after release; one instruction per cycle thereafter.
REQ-038 stall=1 for 3 cycles with BUF_DEPTH=2 -> instr_out/pc_out held, imem_req stops once count=2, no data lost, and the sequence resumes in order after stall drops.
REQ-039 3-cycle memory latency -> a new request only after each rvalid; instr_valid has gaps; pc_out steps by 4.
REQ-040 redirect to 0x0000_0103 while in WAIT -> the late response is discarded (DROP), the next imem_addr is 0x100, chng2nop pulses once, and instr_valid=0 until the 0x100 data arrives.
REQ-041 redirect in the same cycle as rvalid and stall=1 -> FIFO empties, no push, next cycle IDLE issues to the target.
REQ-042 nrst=0 asserted while in WAIT, then rvalid, then release -> response ignored, fetch restarts at RESET_PC, count=0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a small {pc, instr} buffer
// and a single outstanding memory request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        chng2nop
);

  localparam int          PW  = $clog2(BUF_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_RESET, S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, req_pc;
  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          chng2nop_q, push, pop, issue, can_issue;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // occ is the occupancy after this cycle's push/pop; issuing only while it
  // stays below BUF_DEPTH reserves a slot for the single in-flight response.
  always_comb begin
    push = nrst && !redirect && (state == S_WAIT) && imem_rvalid;
    pop  = nrst && !redirect && !stall && (count != '0);
    occ  = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    case (state)
      S_RESET, S_IDLE: can_issue = 1'b1;
      default:         can_issue = imem_rvalid;
    endcase
    issue = nrst && !redirect && can_issue && (occ < (CW+1)'(BUF_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= S_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect) begin
      case (state)
        S_WAIT, S_DROP: state_nxt = imem_rvalid ? S_IDLE : S_DROP;
        default:        state_nxt = S_IDLE;
      endcase
    end else if (issue) begin
      state_nxt = S_WAIT;
    end else begin
      case (state)
        S_RESET:        state_nxt = S_IDLE;
        S_WAIT, S_DROP: state_nxt = imem_rvalid ? S_IDLE : state;
        default:        state_nxt = state;
      endcase
    end
  end

  always_comb begin
    imem_req    = issue;
    imem_addr   = fetch_pc;
    instr_valid = nrst && (count != '0);
    instr_out   = NOP;
    pc_out      = '0;
    if (instr_valid) begin
      instr_out = buf_instr[head];
      pc_out    = buf_pc[head];
    end
    chng2nop = nrst && chng2nop_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      chng2nop_q <= 1'b0;
    end else begin
      chng2nop_q <= redirect;
      if (redirect) begin
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (push) begin
          buf_pc[tail]    <= req_pc;
          buf_instr[tail] <= imem_rdata;
          tail            <= tail + 1'b1;
        end
        if (pop) head <= head + 1'b1;
        count <= occ[CW-1:0];
        if (issue) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: memory model with
// variable latency and an in-order {pc, instr} scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst, stall, redirect, imem_req, imem_rvalid, instr_valid, chng2nop;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr_out, pc_out;

  int n_checks = 0;
  int n_err    = 0;

  // memory model: one pending request, answered when pend_cnt reaches 1
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  int          lat = 1;
  int          proto_viol = 0;

  logic        s_req, s_valid, s_c2n, s_rvalid;
  logic [31:0] s_addr, s_instr, s_pc;
  logic [31:0] exp_pc = RESET_PC;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .nrst(nrst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_out(instr_out),
    .pc_out(pc_out), .instr_valid(instr_valid), .chng2nop(chng2nop)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    if (a == 32'h4) return 32'h00100113;
    return a ^ 32'h5A5A_0013;
  endfunction

  // one clock: inputs already set at the falling edge, sample 1ns later
  task automatic cycle();
    logic resp;
    resp        = pend && (pend_cnt == 1);
    imem_rvalid = resp;
    imem_rdata  = resp ? mem_word(pend_addr) : $urandom();
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr_out; s_pc = pc_out; s_c2n = chng2nop; s_rvalid = resp;
    if (s_req && pend && !resp) proto_viol++;
    if (resp) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (s_req) begin pend = 1'b1; pend_addr = s_addr; pend_cnt = lat; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", s_req); end
      n_checks++; if ({s_valid, s_instr, s_pc, s_c2n} !== {1'b0, NOP, 32'h0, 1'b0}) begin
        n_err++; $display("FAIL reset_outs: got valid=%b instr=%h pc=%h c2n=%b want 0/%h/0/0", s_valid, s_instr, s_pc, s_c2n, NOP); end
    end
  endtask

  task automatic test_stream();
    lat = 1; nrst = 1'b1; exp_pc = RESET_PC;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_checks++; if ({s_req, s_addr} !== {1'b1, RESET_PC + 32'(4*k)}) begin
        n_err++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h want 1/%h", k, s_req, s_addr, RESET_PC + 32'(4*k)); end
      if (k < 2) begin
        n_checks++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency[%0d]: got valid=%b want 0", k, s_valid); end
      end else begin
        n_checks++; if ({s_valid, s_pc, s_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
          n_err++; $display("FAIL stream_pop[%0d]: got %b/%h/%h want 1/%h/%h", k, s_valid, s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_instr;
    stall = 1'b1;
    cycle();
    held_pc = s_pc; held_instr = s_instr;
    n_checks++; if ({s_valid, s_pc} !== {1'b1, exp_pc}) begin n_err++; $display("FAIL stall_head: got %b/%h want 1/%h", s_valid, s_pc, exp_pc); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++; if ({s_valid, s_pc, s_instr} !== {1'b1, held_pc, held_instr}) begin
        n_err++; $display("FAIL stall_hold: got %b/%h/%h want 1/%h/%h", s_valid, s_pc, s_instr, held_pc, held_instr); end
      n_checks++; if (s_req !== 1'b0) begin n_err++; $display("FAIL stall_full_req: got %b want 0", s_req); end
    end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++; if ({s_valid, s_pc, s_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
        n_err++; $display("FAIL stall_resume: got %b/%h/%h want 1/%h/%h", s_valid, s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
      if (s_valid) exp_pc += 4;
    end
  endtask

  task automatic test_latency3();
    int last_req, spacing_viol, gaps;
    lat = 3; last_req = -100; spacing_viol = 0; gaps = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (s_req) begin
        if (c - last_req < 3) spacing_viol++;
        last_req = c;
      end
      if (!s_valid && c >= 6) gaps++;
      if (s_valid) begin
        n_checks++; if ({s_pc, s_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          n_err++; $display("FAIL lat3_pop: got %h/%h want %h/%h", s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4;
      end
    end
    n_checks++; if (spacing_viol !== 0) begin n_err++; $display("FAIL lat3_spacing: got %0d early requests want 0", spacing_viol); end
    n_checks++; if (gaps == 0) begin n_err++; $display("FAIL lat3_gaps: got %0d empty cycles want >0", gaps); end
  endtask

  task automatic test_redirect_wait();
    bit found; int c2n_cnt, pops; logic [31:0] first_addr; bit got_req;
    found = 0; c2n_cnt = 0; pops = 0; got_req = 0; first_addr = '0;
    for (int i = 0; i < 12; i++) begin
      if (pend && pend_cnt >= 2) begin found = 1; break; end
      cycle();
    end
    n_checks++; if (!found) begin n_err++; $display("FAIL redir_wait_timeout: got no WAIT window want one"); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    cycle();
    n_checks++; if (s_req !== 1'b0) begin n_err++; $display("FAIL redir_wait_noissue: got %b want 0", s_req); end
    redirect = 1'b0; exp_pc = 32'h0000_0100;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (s_c2n) c2n_cnt++;
      if (s_req && !got_req) begin got_req = 1; first_addr = s_addr; end
      if (s_valid) begin
        n_checks++; if ({s_pc, s_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          n_err++; $display("FAIL redir_wait_pop: got %h/%h want %h/%h", s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4; pops++;
      end
    end
    n_checks++; if (c2n_cnt !== 1) begin n_err++; $display("FAIL redir_wait_c2n: got %0d pulses want 1", c2n_cnt); end
    n_checks++; if (first_addr !== 32'h100) begin n_err++; $display("FAIL redir_wait_addr: got %h want 00000100", first_addr); end
    n_checks++; if (pops == 0) begin n_err++; $display("FAIL redir_wait_data: got 0 pops want >0"); end
  endtask

  task automatic test_redirect_rvalid_stall();
    logic [31:0] tgt; int pops;
    lat = 1; pops = 0; tgt = $urandom();
    for (int i = 0; i < 8; i++) begin
      if (pend && pend_cnt == 1) break;
      cycle();
    end
    stall = 1'b1; redirect = 1'b1; redirect_pc = tgt;
    cycle();
    n_checks++; if ({s_rvalid, s_req} !== 2'b10) begin n_err++; $display("FAIL redir_rv_cycle: got rvalid=%b req=%b want 1/0", s_rvalid, s_req); end
    stall = 1'b0; redirect = 1'b0; exp_pc = {tgt[31:2], 2'b00};
    cycle();
    n_checks++; if ({s_valid, s_req, s_addr, s_c2n} !== {1'b0, 1'b1, exp_pc, 1'b1}) begin
      n_err++; $display("FAIL redir_rv_next: got valid=%b req=%b addr=%h c2n=%b want 0/1/%h/1", s_valid, s_req, s_addr, s_c2n, exp_pc); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (s_valid) begin
        n_checks++; if ({s_pc, s_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          n_err++; $display("FAIL redir_rv_pop: got %h/%h want %h/%h", s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4; pops++;
      end
    end
    n_checks++; if (pops == 0) begin n_err++; $display("FAIL redir_rv_data: got 0 pops want >0"); end
  endtask

  task automatic test_wrap();
    bit saw_zero; logic [31:0] last_pc;
    saw_zero = 0; last_pc = '0; lat = 1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0; exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_valid) begin
        n_checks++; if ({s_pc, s_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          n_err++; $display("FAIL wrap_pop: got %h/%h want %h/%h", s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
        if (s_pc == 32'h0 && last_pc == 32'hFFFF_FFFC) saw_zero = 1;
        last_pc = s_pc; exp_pc += 4;
      end
    end
    n_checks++; if (!saw_zero) begin n_err++; $display("FAIL wrap_seen: got no FFFFFFFC->0 step want one"); end
  endtask

  task automatic test_reset_midflight();
    int pops;
    lat = 3; pops = 0;
    for (int i = 0; i < 12; i++) begin
      if (pend && pend_cnt == 3) break;
      cycle();
    end
    nrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if ({s_req, s_valid, s_instr, s_pc, s_c2n} !== {1'b0, 1'b0, NOP, 32'h0, 1'b0}) begin
        n_err++; $display("FAIL midrst_outs: got req=%b valid=%b instr=%h pc=%h c2n=%b want 0/0/%h/0/0", s_req, s_valid, s_instr, s_pc, s_c2n, NOP); end
    end
    n_checks++; if (s_rvalid !== 1'b1) begin n_err++; $display("FAIL midrst_late_rvalid: got %b want 1", s_rvalid); end
    nrst = 1'b1; exp_pc = RESET_PC;
    cycle();
    n_checks++; if ({s_req, s_addr, s_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      n_err++; $display("FAIL midrst_restart: got req=%b addr=%h valid=%b want 1/%h/0", s_req, s_addr, s_valid, RESET_PC); end
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_valid) begin
        n_checks++; if ({s_pc, s_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          n_err++; $display("FAIL midrst_pop: got %h/%h want %h/%h", s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4; pops++;
      end
    end
    n_checks++; if (pops == 0) begin n_err++; $display("FAIL midrst_data: got 0 pops want >0"); end
  endtask

  task automatic test_random();
    bit prev_hold, prev_redir; logic [31:0] prev_pc, prev_instr; int pops;
    prev_hold = 0; prev_redir = 0; prev_pc = '0; prev_instr = '0; pops = 0;
    for (int c = 0; c < 600; c++) begin
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      lat         = $urandom_range(1, 4);
      cycle();
      if (s_valid && !stall && !redirect) begin
        n_checks++; if ({s_pc, s_instr} !== {exp_pc, mem_word(exp_pc)}) begin
          n_err++; $display("FAIL rand_pop@%0d: got %h/%h want %h/%h", c, s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
        exp_pc += 4; pops++;
      end
      if (prev_hold) begin
        n_checks++; if ({s_valid, s_pc, s_instr} !== {1'b1, prev_pc, prev_instr}) begin
          n_err++; $display("FAIL rand_hold@%0d: got %b/%h/%h want 1/%h/%h", c, s_valid, s_pc, s_instr, prev_pc, prev_instr); end
      end
      n_checks++; if (s_c2n !== prev_redir) begin n_err++; $display("FAIL rand_c2n@%0d: got %b want %b", c, s_c2n, prev_redir); end
      if (redirect) begin
        n_checks++; if (s_req !== 1'b0) begin n_err++; $display("FAIL rand_redir_noissue@%0d: got %b want 0", c, s_req); end
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
      prev_hold = s_valid && stall && !redirect;
      prev_pc = s_pc; prev_instr = s_instr; prev_redir = redirect;
    end
    stall = 1'b0; redirect = 1'b0;
    n_checks++; if (proto_viol !== 0) begin n_err++; $display("FAIL one_outstanding: got %0d overlaps want 0", proto_viol); end
    n_checks++; if (pops < 50) begin n_err++; $display("FAIL rand_progress: got %0d pops want >=50", pops); end
  endtask

  initial begin
    nrst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_latency3();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
